sdram_req_server: RTL

Responder end of the SDRAM request-buffer interface. It accepts single-cycle request pushes (address, write data, read/write flag) from the CPU/GPU arbitration logic into a request FIFO and reports `sdram_buffer_empty`/`sdram_buffer_full` back to the requester. It drains requests one at a time into a valid/ready memory command port and returns read data on `data_output` with its `current_address`. It sits between the top-level request arbiter and the SDRAM command sequencer, all in the `clk50` domain.

---
 rtl/sdram_req_pkg.sv | 20 ++
 rtl/req_fifo.sv | 66 ++++++
 rtl/sdram_req_server.sv | 111 +++++++++++
 3 files changed

// File: rtl/sdram_req_pkg.sv
// Shared types for the SDRAM request server: default widths, the queued
// request record and the command FSM states.
package sdram_req_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic                  rw;
  } req_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO with registered empty/full flags derived from
// the next occupancy count, so both flags are valid right after each edge.
module req_fifo
  import sdram_req_pkg::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = req_t
) (
  input  logic   clk50,
  input  logic   reset,
  input  logic   push,
  input  entry_t din,
  input  logic   pop,
  output entry_t dout,
  output logic   empty,
  output logic   full
);

  localparam int              PW       = $clog2(DEPTH);
  localparam logic [PW:0]     CNT_ONE  = 1;
  localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW-1:0]   PTR_ONE  = 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_next;
  logic          push_ok;
  logic          pop_ok;

  // A push while full is dropped even if a pop happens on the same edge.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == CNT_FULL);
    end
  end

  always_ff @(posedge clk50) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdram_req_server.sv
// Drains queued SDRAM requests one at a time onto a valid/ready command port
// and captures read return data together with the address it came from.
module sdram_req_server
  import sdram_req_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 8
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic [ADDR_W-1:0] sdram_buffer_addr_in,
  input  logic [DATA_W-1:0] sdram_buffer_data_in,
  input  logic              sdram_buffer_rw_in,
  input  logic              sdram_buffer_wrreq,
  output logic              sdram_buffer_empty,
  output logic              sdram_buffer_full,
  output logic              overflow,
  output logic [DATA_W-1:0] data_output,
  output logic [ADDR_W-1:0] current_address,
  output logic              rd_valid,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              rw;
  } cmd_req_t;

  cmd_req_t push_req;
  cmd_req_t head_req;
  state_t   state;
  logic     pop;

  assign push_req = '{addr: sdram_buffer_addr_in,
                      data: sdram_buffer_data_in,
                      rw:   sdram_buffer_rw_in};
  assign pop      = (state == IDLE) && !sdram_buffer_empty;

  req_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (cmd_req_t)
  ) u_fifo (
    .clk50 (clk50),
    .reset (reset),
    .push  (sdram_buffer_wrreq),
    .din   (push_req),
    .pop   (pop),
    .dout  (head_req),
    .empty (sdram_buffer_empty),
    .full  (sdram_buffer_full)
  );

  always_ff @(posedge clk50) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (sdram_buffer_wrreq && sdram_buffer_full) begin
      overflow <= 1'b1;
    end
  end

  // Writes are posted after the handshake; reads park in WAIT_RD until data returns.
  always_ff @(posedge clk50) begin
    if (reset) begin
      state           <= IDLE;
      mem_cmd_valid   <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      data_output     <= '0;
      current_address <= '0;
      rd_valid        <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!sdram_buffer_empty) begin
            mem_addr      <= head_req.addr;
            mem_wdata     <= head_req.data;
            mem_we        <= head_req.rw;
            mem_cmd_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= mem_we ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (mem_rdata_valid) begin
            data_output     <= mem_rdata;
            current_address <= mem_addr;
            rd_valid        <= 1'b1;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
